// File: rtl/acc_reg_file.sv
// Accumulator plus DEPTH-entry register file with registered reads and per-entry written-since-reset flags.
// Define ACC_RF_BYPASS_EN to forward a same-cycle register write to the read/load path.
module acc_reg_file #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] ReadAddr,
  input  logic          ReadRegEn,
  input  logic          LoadACCEn,
  input  logic [AW-1:0] RegWriteAddr,
  input  logic          WriteRegEn,
  input  logic          WriteACCEn,
  input  logic [W-1:0]  ACCWrite,
  output logic [W-1:0]  ACCRead,
  output logic [W-1:0]  ReadDataOut,
  output logic          ReadUninit
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [W-1:0]     acc;
  logic [W-1:0]     read_data;
  logic             read_uninit;

  logic             rd_in_range;
  logic             wr_in_range;
  logic [W-1:0]     mem_rd;
  logic             valid_rd;
  logic [W-1:0]     rd_data;
  logic             rd_valid;

  // Addresses past DEPTH read as an unwritten zero and never store.
  assign rd_in_range = {1'b0, ReadAddr} < DEPTH_W;
  assign wr_in_range = {1'b0, RegWriteAddr} < DEPTH_W;
  assign mem_rd      = rd_in_range ? mem[ReadAddr] : '0;
  assign valid_rd    = rd_in_range & valid[ReadAddr];

`ifdef ACC_RF_BYPASS_EN
  logic fwd_hit;

  // A same-address write hands the outgoing ACC straight to the read/load path.
  assign fwd_hit  = WriteRegEn & wr_in_range & (RegWriteAddr == ReadAddr);
  assign rd_data  = fwd_hit ? acc : mem_rd;
  assign rd_valid = fwd_hit | valid_rd;
`else
  assign rd_data  = mem_rd;
  assign rd_valid = valid_rd;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc <= '0;
    end else if (WriteACCEn) begin
      acc <= ACCWrite;
    end else if (LoadACCEn) begin
      acc <= rd_data;
    end
  end

  // Stores always take the pre-edge ACC, which makes store-and-replace and swap single-cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (WriteRegEn && wr_in_range) begin
      mem[RegWriteAddr]   <= acc;
      valid[RegWriteAddr] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      read_data   <= '0;
      read_uninit <= 1'b0;
    end else if (ReadRegEn) begin
      read_data   <= rd_data;
      read_uninit <= ~rd_valid;
    end
  end

  assign ACCRead     = acc;
  assign ReadDataOut = read_data;
  assign ReadUninit  = read_uninit;

endmodule

// File: tb/tb_acc_reg_file.sv
// Self-checking bench for acc_reg_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_acc_reg_file;

`ifdef ACC_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  // Instance A: default 8-bit x 16
  logic [3:0] read_addr, wr_addr;
  logic       read_en, load_en, wr_en, acc_wr_en;
  logic [7:0] acc_wr_data, acc_rd, rd_data;
  logic       rd_uninit;

  // Instance B: 16-bit x 12 (addresses 12..15 are out of range)
  logic [3:0]  read_addr_b, wr_addr_b;
  logic        read_en_b, load_en_b, wr_en_b, acc_wr_en_b;
  logic [15:0] acc_wr_data_b, acc_rd_b, rd_data_b;
  logic        rd_uninit_b;

  acc_reg_file dut_a (
    .CLK(CLK), .RST_N(RST_N), .ReadAddr(read_addr), .ReadRegEn(read_en),
    .LoadACCEn(load_en), .RegWriteAddr(wr_addr), .WriteRegEn(wr_en),
    .WriteACCEn(acc_wr_en), .ACCWrite(acc_wr_data), .ACCRead(acc_rd),
    .ReadDataOut(rd_data), .ReadUninit(rd_uninit)
  );

  acc_reg_file #(.W(16), .DEPTH(12)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .ReadAddr(read_addr_b), .ReadRegEn(read_en_b),
    .LoadACCEn(load_en_b), .RegWriteAddr(wr_addr_b), .WriteRegEn(wr_en_b),
    .WriteACCEn(acc_wr_en_b), .ACCWrite(acc_wr_data_b), .ACCRead(acc_rd_b),
    .ReadDataOut(rd_data_b), .ReadUninit(rd_uninit_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference state for instance A
  logic [7:0] m_mem [16];
  bit         m_written [16];
  logic [7:0] m_acc, m_rd;
  bit         m_un;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      m_written[i] = 1'b0;
    end
    m_acc = 8'h00;
    m_rd  = 8'h00;
    m_un  = 1'b0;
  endtask

  task automatic idle_all();
    read_addr = 0; wr_addr = 0; read_en = 0; load_en = 0; wr_en = 0; acc_wr_en = 0; acc_wr_data = 0;
    read_addr_b = 0; wr_addr_b = 0; read_en_b = 0; load_en_b = 0; wr_en_b = 0; acc_wr_en_b = 0; acc_wr_data_b = 0;
  endtask

  // Entered at posedge+1; returns at the following posedge+1 with all enables released.
  task automatic pulse_reset();
    idle_all();
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  // One clock of instance A; the model applies the register-file rules to the pre-edge state.
  task automatic step_a(input logic [3:0] ra, input bit re, input bit le,
                        input logic [3:0] wa, input bit we, input bit ae, input logic [7:0] ad);
    logic [7:0] seen;
    bit         seen_written;
    logic [7:0] next_acc;
    read_addr = ra; read_en = re; load_en = le;
    wr_addr = wa; wr_en = we; acc_wr_en = ae; acc_wr_data = ad;
    if (BYP && we && (wa == ra)) begin
      seen = m_acc;
      seen_written = 1'b1;
    end else begin
      seen = m_mem[ra];
      seen_written = m_written[ra];
    end
    next_acc = ae ? ad : (le ? seen : m_acc);
    if (we) begin
      m_mem[wa] = m_acc;
      m_written[wa] = 1'b1;
    end
    if (re) begin
      m_rd = seen;
      m_un = !seen_written;
    end
    m_acc = next_acc;
    @(posedge CLK); #1;
    read_en = 0; load_en = 0; wr_en = 0; acc_wr_en = 0;
  endtask

  task automatic step_b(input logic [3:0] ra, input bit re, input bit le,
                        input logic [3:0] wa, input bit we, input bit ae, input logic [15:0] ad);
    read_addr_b = ra; read_en_b = re; load_en_b = le;
    wr_addr_b = wa; wr_en_b = we; acc_wr_en_b = ae; acc_wr_data_b = ad;
    @(posedge CLK); #1;
    read_en_b = 0; load_en_b = 0; wr_en_b = 0; acc_wr_en_b = 0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (acc_rd !== 8'h00) begin failures++; $display("FAIL reset_acc got %h want 00", acc_rd); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd got %h want 00", rd_data); end
    checks++; if (rd_uninit !== 1'b0) begin failures++; $display("FAIL reset_uninit got %b want 0", rd_uninit); end
    step_a(4'd9, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_read9 got %h want 00", rd_data); end
    checks++; if (rd_uninit !== 1'b1) begin failures++; $display("FAIL reset_read9_uninit got %b want 1", rd_uninit); end
    checks++; if (acc_rd !== 8'h00) begin failures++; $display("FAIL reset_read9_acc got %h want 00", acc_rd); end
  endtask

  task automatic test_store();
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'h07);
    checks++; if (acc_rd !== 8'h07) begin failures++; $display("FAIL store_acc got %h want 07", acc_rd); end
    step_a(4'd0, 0, 0, 4'd1, 1, 0, 8'h00);
    step_a(4'd1, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h07) begin failures++; $display("FAIL store_read got %h want 07", rd_data); end
    checks++; if (rd_uninit !== 1'b0) begin failures++; $display("FAIL store_uninit got %b want 0", rd_uninit); end
    step_a(4'd5, 0, 0, 4'd0, 0, 0, 8'h00);
    step_a(4'd6, 0, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h07) begin failures++; $display("FAIL store_hold got %h want 07", rd_data); end
  endtask

  task automatic test_swap();
    logic [7:0] want_acc;
    want_acc = BYP ? 8'h3C : 8'hA5;
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'hA5);
    step_a(4'd0, 0, 0, 4'd4, 1, 0, 8'h00);
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'h3C);
    step_a(4'd4, 0, 1, 4'd4, 1, 0, 8'h00);
    checks++; if (acc_rd !== want_acc) begin failures++; $display("FAIL swap_acc got %h want %h", acc_rd, want_acc); end
    step_a(4'd4, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h3C) begin failures++; $display("FAIL swap_mem4 got %h want 3c", rd_data); end
  endtask

  task automatic test_same_addr_read();
    logic [7:0] want_d;
    bit         want_u;
    want_d = BYP ? 8'h55 : 8'h00;
    want_u = BYP ? 1'b0 : 1'b1;
    pulse_reset();
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'h55);
    step_a(4'd2, 1, 0, 4'd2, 1, 0, 8'h00);
    checks++; if (rd_data !== want_d) begin failures++; $display("FAIL same_addr_data got %h want %h", rd_data, want_d); end
    checks++; if (rd_uninit !== want_u) begin failures++; $display("FAIL same_addr_uninit got %b want %b", rd_uninit, want_u); end
    step_a(4'd2, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h55 || rd_uninit !== 1'b0) begin
      failures++; $display("FAIL same_addr_after got %h/%b want 55/0", rd_data, rd_uninit);
    end
  endtask

  task automatic test_priority();
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'h99);
    step_a(4'd0, 0, 0, 4'd0, 1, 0, 8'h00);
    step_a(4'd0, 0, 0, 4'd0, 0, 1, 8'h11);
    step_a(4'd0, 0, 1, 4'd3, 1, 1, 8'h22);
    checks++; if (acc_rd !== 8'h22) begin failures++; $display("FAIL priority_acc got %h want 22", acc_rd); end
    step_a(4'd3, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h11) begin failures++; $display("FAIL priority_mem3 got %h want 11", rd_data); end
  endtask

  task automatic test_random();
    logic [3:0] ra, wa;
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      step_a(ra, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, wa,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
      checks++; if (acc_rd !== m_acc) begin failures++; $display("FAIL random_acc cycle %0d got %h want %h", n, acc_rd, m_acc); end
      checks++; if (rd_data !== m_rd) begin failures++; $display("FAIL random_rd cycle %0d got %h want %h", n, rd_data, m_rd); end
      checks++; if (rd_uninit !== m_un) begin failures++; $display("FAIL random_uninit cycle %0d got %b want %b", n, rd_uninit, m_un); end
    end
  endtask

  task automatic test_param16();
    step_b(4'd0, 0, 0, 4'd0, 0, 1, 16'hBEEF);
    step_b(4'd0, 0, 0, 4'd11, 1, 0, 16'h0000);
    step_b(4'd11, 1, 0, 4'd0, 0, 0, 16'h0000);
    checks++; if (rd_data_b !== 16'hBEEF || rd_uninit_b !== 1'b0) begin
      failures++; $display("FAIL p16_read11 got %h/%b want beef/0", rd_data_b, rd_uninit_b);
    end
    step_b(4'd0, 0, 0, 4'd13, 1, 0, 16'h0000);
    step_b(4'd13, 1, 0, 4'd0, 0, 0, 16'h0000);
    checks++; if (rd_data_b !== 16'h0000) begin failures++; $display("FAIL p16_read13 got %h want 0000", rd_data_b); end
    checks++; if (rd_uninit_b !== 1'b1) begin failures++; $display("FAIL p16_read13_uninit got %b want 1", rd_uninit_b); end
    step_b(4'd13, 0, 1, 4'd0, 0, 0, 16'h0000);
    checks++; if (acc_rd_b !== 16'h0000) begin failures++; $display("FAIL p16_load13 got %h want 0000", acc_rd_b); end
    step_b(4'd11, 0, 1, 4'd0, 0, 0, 16'h0000);
    checks++; if (acc_rd_b !== 16'hBEEF) begin failures++; $display("FAIL p16_load11 got %h want beef", acc_rd_b); end
  endtask

  task automatic test_async_reset();
    step_b(4'd11, 1, 0, 4'd0, 0, 1, 16'h1234);
    step_a(4'd3, 1, 0, 4'd0, 0, 1, 8'h5A);
    checks++; if (acc_rd !== 8'h5A || rd_data !== m_rd) begin
      failures++; $display("FAIL async_pre got %h/%h want 5a/%h", acc_rd, rd_data, m_rd);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (acc_rd !== 8'h00) begin failures++; $display("FAIL async_acc got %h want 00", acc_rd); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL async_rd got %h want 00", rd_data); end
    checks++; if (acc_rd_b !== 16'h0000 || rd_data_b !== 16'h0000) begin
      failures++; $display("FAIL async_b got %h/%h want 0000/0000", acc_rd_b, rd_data_b);
    end
    @(posedge CLK);
    #2 RST_N = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    step_a(4'd3, 1, 0, 4'd0, 0, 0, 8'h00);
    checks++; if (rd_data !== 8'h00 || rd_uninit !== 1'b1) begin
      failures++; $display("FAIL async_cleared got %h/%b want 00/1", rd_data, rd_uninit);
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    @(posedge CLK); #1;
    test_reset();
    test_store();
    test_swap();
    test_same_addr_read();
    test_priority();
    test_random();
    test_param16();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
